// File: rtl/jtag_tap_driver.sv
// JTAG master that drives the debug TAP of a target from a valid/ready scan-request port.
// After reset it walks the TAP through Test-Logic-Reset into Run-Test/Idle. Each request is
// then run as one complete IR or DR scan that starts and ends in Run-Test/Idle.
// TCK is free-running. TMS and TDI change only when TCK falls, and TDO is sampled only when
// TCK rises.
module jtag_tap_driver #(
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_ir_i,
    input  logic [LEN_W-1:0]   req_len_i,
    input  logic [MAX_LEN-1:0] req_data_i,
    output logic               rsp_valid_o,
    output logic [MAX_LEN-1:0] rsp_data_o,
    output logic               tck_o,
    output logic               tms_o,
    output logic               tdi_o,
    output logic               trst_no,
    input  logic               tdo_i
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [DivW-1:0]  DivLast = DivW'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] LenMax  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LenOne  = LEN_W'(1);
    // This is the number of TMS=1 cycles that force the TAP into Test-Logic-Reset.
    localparam logic [2:0]       TlrOnes = 3'd5;

    typedef enum logic [2:0] {
        StTlrSeq,
        StIdle,
        StPre,
        StShift,
        StPost,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [DivW-1:0]    div_q, div_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               trst_q, trst_d;
    logic               ir_q, ir_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] rsp_q, rsp_d;
    logic [LEN_W-1:0]   bit_q, bit_d;
    logic [2:0]         step_q, step_d;

    logic               div_tc;
    logic               tck_fall;
    logic               tck_rise;
    logic               last_bit;
    logic [2:0]         pre_len;
    logic [IdxW-1:0]    bit_idx;
    logic [LEN_W-1:0]   req_len_clamped;

    // Decode the TCK edges one clk_i cycle ahead, plus the shift-position helpers.
    always_comb begin
        div_tc          = (div_q == DivLast);
        tck_fall        = div_tc & tck_q;
        tck_rise        = div_tc & ~tck_q;
        last_bit        = (bit_q == (len_q - LenOne));
        // An IR scan needs one extra Select-IR step before it reaches Capture-IR.
        pre_len         = ir_q ? 3'd4 : 3'd3;
        bit_idx         = bit_q[IdxW-1:0];
        req_len_clamped = (req_len_i > LenMax) ? LenMax : req_len_i;
    end

    // Next-state logic: the TCK divider and the scan sequencer.
    always_comb begin
        state_d = state_q;
        div_d   = div_tc ? '0 : div_q + DivW'(1);
        tck_d   = div_tc ? ~tck_q : tck_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        trst_d  = 1'b1;
        ir_d    = ir_q;
        len_d   = len_q;
        data_d  = data_q;
        rsp_d   = rsp_q;
        bit_d   = bit_q;
        step_d  = step_q;

        unique case (state_q)
            StTlrSeq: begin
                // step_q counts rising edges. Present five ones, then a single zero.
                if (tck_fall) begin
                    tms_d = (step_q < TlrOnes);
                end
                if (tck_rise) begin
                    if (step_q == TlrOnes) begin
                        state_d = StIdle;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end

            StIdle: begin
                if (req_valid_i) begin
                    ir_d   = req_ir_i;
                    len_d  = req_len_clamped;
                    data_d = req_data_i;
                    rsp_d  = '0;
                    bit_d  = '0;
                    step_d = '0;
                    state_d = (req_len_clamped == '0) ? StDone : StPre;
                end
            end

            StPre: begin
                // step_q counts the TMS values already presented. Rising edges that occur
                // before the first presented value only keep the TAP in Run-Test/Idle.
                if (tck_fall && (step_q < pre_len)) begin
                    tms_d  = (step_q == 3'd0) || (ir_q && (step_q == 3'd1));
                    step_d = step_q + 3'd1;
                end
                if (tck_rise && (step_q == pre_len)) begin
                    state_d = StShift;
                    step_d  = '0;
                    bit_d   = '0;
                end
            end

            StShift: begin
                if (tck_fall) begin
                    tdi_d = data_q[bit_idx];
                    tms_d = last_bit;
                end
                if (tck_rise) begin
                    rsp_d[bit_idx] = tdo_i;
                    if (last_bit) begin
                        state_d = StPost;
                        step_d  = '0;
                    end else begin
                        bit_d = bit_q + LenOne;
                    end
                end
            end

            StPost: begin
                // Exit1 -> Update (TMS=1) -> Run-Test/Idle (TMS=0).
                if (tck_fall && (step_q < 3'd2)) begin
                    tms_d  = (step_q == 3'd0);
                    step_d = step_q + 3'd1;
                end
                if (tck_rise && (step_q == 3'd2)) begin
                    state_d = StDone;
                    step_d  = '0;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StTlrSeq;
            end
        endcase
    end

    // State register. A reset aborts any scan in flight and restarts the TLR walk.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StTlrSeq;
            div_q   <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            trst_q  <= 1'b0;
            ir_q    <= 1'b0;
            len_q   <= '0;
            data_q  <= '0;
            rsp_q   <= '0;
            bit_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            trst_q  <= trst_d;
            ir_q    <= ir_d;
            len_q   <= len_d;
            data_q  <= data_d;
            rsp_q   <= rsp_d;
            bit_q   <= bit_d;
            step_q  <= step_d;
        end
    end

    // Output mapping. Every output comes straight from a register or a state decode.
    always_comb begin
        req_ready_o = (state_q == StIdle);
        rsp_valid_o = (state_q == StDone);
        rsp_data_o  = rsp_q;
        tck_o       = tck_q;
        tms_o       = tms_q;
        tdi_o       = tdi_q;
        trst_no     = trst_q;
    end

endmodule

// File: tb/tb_jtag_tap_driver.sv
// Directed bench for jtag_tap_driver. The bench contains a behavioural IEEE 1149.1 TAP
// with a 5-bit IR (IDCODE=1 on reset), a 32-bit IDCODE register and a 1-bit bypass
// register. In bypass, TDO is TDI delayed by one shift.
module tb_jtag_tap_driver;

    localparam logic [3:0] TLR  = 4'd0,  RTI  = 4'd1,  SDR  = 4'd2,  CDR  = 4'd3;
    localparam logic [3:0] SHDR = 4'd4,  E1DR = 4'd5,  PDR  = 4'd6,  E2DR = 4'd7;
    localparam logic [3:0] UDR  = 4'd8,  SIR  = 4'd9,  CIR  = 4'd10, SHIR = 4'd11;
    localparam logic [3:0] E1IR = 4'd12, PIR  = 4'd13, E2IR = 4'd14, UIR  = 4'd15;
    localparam logic [31:0] IdCode = 32'h2495_11C3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ir = 1'b0;
    logic [6:0]  req_len = '0;
    logic [63:0] req_data = '0;
    logic        req_ready_o, rsp_valid_o, tck_o, tms_o, tdi_o, trst_no;
    logic [63:0] rsp_data_o;
    logic        tdo_r = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0]  tap_st = TLR;
    logic [4:0]  tap_ir = 5'h01;
    logic [4:0]  ir_sr = '0;
    logic [31:0] dr_sr = '0;
    logic [63:0] tms_log = '0;
    int          tck_cnt = 0;
    int          shdr_cnt = 0;
    time         last_rise = 0;
    time         tck_period = 0;

    jtag_tap_driver #(
        .MAX_LEN(64),
        .CLK_DIV(4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready_o),
        .req_ir_i   (req_ir),
        .req_len_i  (req_len),
        .req_data_i (req_data),
        .rsp_valid_o(rsp_valid_o),
        .rsp_data_o (rsp_data_o),
        .tck_o      (tck_o),
        .tms_o      (tms_o),
        .tdi_o      (tdi_o),
        .trst_no    (trst_no),
        .tdo_i      (tdo_r)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic t);
        case (s)
            TLR:     tap_next = t ? TLR  : RTI;
            RTI:     tap_next = t ? SDR  : RTI;
            SDR:     tap_next = t ? SIR  : CDR;
            CDR:     tap_next = t ? E1DR : SHDR;
            SHDR:    tap_next = t ? E1DR : SHDR;
            E1DR:    tap_next = t ? UDR  : PDR;
            PDR:     tap_next = t ? E2DR : PDR;
            E2DR:    tap_next = t ? UDR  : SHDR;
            UDR:     tap_next = t ? SDR  : RTI;
            SIR:     tap_next = t ? TLR  : CIR;
            CIR:     tap_next = t ? E1IR : SHIR;
            SHIR:    tap_next = t ? E1IR : SHIR;
            E1IR:    tap_next = t ? UIR  : PIR;
            PIR:     tap_next = t ? E2IR : PIR;
            E2IR:    tap_next = t ? UIR  : SHIR;
            default: tap_next = t ? SDR  : RTI;
        endcase
    endfunction

    // TAP model. Rising edges in Run-Test/Idle with TMS=0 are idle and go unlogged.
    always @(posedge tck_o or negedge trst_no) begin
        if (!trst_no) begin
            tap_st <= TLR;
            tap_ir <= 5'h01;
        end else begin
            if (tap_st != RTI || tms_o) begin
                tms_log <= {tms_log[62:0], tms_o};
                tck_cnt <= tck_cnt + 1;
            end
            case (tap_st)
                CIR:  ir_sr <= 5'b00001;
                SHIR: ir_sr <= {tdi_o, ir_sr[4:1]};
                CDR:  dr_sr <= (tap_ir == 5'h01) ? IdCode : 32'h0;
                SHDR: begin
                    dr_sr    <= (tap_ir == 5'h01) ? {tdi_o, dr_sr[31:1]} : {31'h0, tdi_o};
                    shdr_cnt <= shdr_cnt + 1;
                end
                default: ;
            endcase
            if (tap_next(tap_st, tms_o) == TLR) tap_ir <= 5'h01;
            else if (tap_st == UIR) tap_ir <= ir_sr;
            tap_st <= tap_next(tap_st, tms_o);
        end
    end

    // The TAP drives TDO on the falling edge of TCK.
    always @(negedge tck_o) begin
        tdo_r <= (tap_st == SHIR) ? ir_sr[0] : (tap_st == SHDR) ? dr_sr[0] : 1'b0;
    end

    always @(posedge tck_o) begin
        tck_period <= $time - last_rise;
        last_rise  <= $time;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".tck"}, tck_o, 0);
        check({tag, ".tms"}, tms_o, 1);
        check({tag, ".tdi"}, tdi_o, 0);
        check({tag, ".trst"}, trst_no, 0);
        check({tag, ".ready"}, req_ready_o, 0);
        check({tag, ".rsp_valid"}, rsp_valid_o, 0);
        check({tag, ".rsp_data"}, rsp_data_o, 0);
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 2000 && !req_ready_o; i++) @(negedge clk);
        check({tag, ".ready"}, req_ready_o, 1);
    endtask

    // One complete scan. Also checks the handshake and the single-cycle response pulse.
    task automatic scan(input string tag, input logic ir, input logic [6:0] len,
                        input logic [63:0] data, output logic [63:0] rsp,
                        output int lat, output int tcks);
        int  c0;
        bit  got;
        wait_ready(tag);
        c0 = tck_cnt;
        req_ir = ir;
        req_len = len;
        req_data = data;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, ".ready_drop"}, req_ready_o, 0);
        got = 1'b0;
        lat = 0;
        while (!got && lat < 4000) begin
            if (rsp_valid_o) got = 1'b1;
            else begin
                lat++;
                @(negedge clk);
            end
        end
        check({tag, ".done"}, got, 1);
        rsp = rsp_data_o;
        tcks = tck_cnt - c0;
        @(negedge clk);
        check({tag, ".pulse_one"}, rsp_valid_o, 0);
        check({tag, ".ready_back"}, req_ready_o, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rsp;
        int          lat;
        int          tcks;
        int          s0;
        int          nv;
        int          i;

        // Reset values, then the Test-Logic-Reset walk.
        repeat (3) @(negedge clk);
        check_reset("rst");
        s0 = tck_cnt;
        rst = 1'b0;
        @(negedge clk);
        check("rst.trst_rise", trst_no, 1);
        wait_ready("tlr");
        check("tlr.tap_rti", tap_st, RTI);
        check("tlr.tms_low", tms_o, 0);
        check("tlr.tms_seq", tms_log & 64'h3F, 64'h3E);
        check("tlr.tck_count", tck_cnt - s0, 6);
        check("tlr.tck_period", tck_period, 80);

        // IR scan of 0x11: the capture pattern comes back and the TAP loads the new IR.
        scan("ir11", 1'b1, 7'd5, 64'h11, rsp, lat, tcks);
        check("ir11.rsp", rsp, 64'h1);
        check("ir11.tms_seq", tms_log & 64'h7FF, 64'h606);
        check("ir11.tcks", tcks, 11);
        check("ir11.tap_ir", tap_ir, 5'h11);
        check("ir11.tap_rti", tap_st, RTI);

        // Select IDCODE and read it.
        scan("ir01", 1'b1, 7'd5, 64'h01, rsp, lat, tcks);
        check("ir01.rsp", rsp, 64'h1);
        check("ir01.tap_ir", tap_ir, 5'h01);
        scan("idcode", 1'b0, 7'd32, 64'h0, rsp, lat, tcks);
        check("idcode.rsp", rsp, 64'h0000_0000_2495_11C3);
        check("idcode.tcks", tcks, 37);
        repeat (20) @(negedge clk);
        check("idcode.hold", rsp_data_o, 64'h0000_0000_2495_11C3);

        // Switch to bypass so that TDO is TDI delayed by one shift.
        scan("irbyp", 1'b1, 7'd5, 64'h1F, rsp, lat, tcks);
        check("irbyp.tap_ir", tap_ir, 5'h1F);
        scan("dmi41", 1'b0, 7'd41, 64'h0000_0012_3456_789A, rsp, lat, tcks);
        check("dmi41.rsp", rsp, 64'h0000_0024_68AC_F134);
        check("dmi41.tcks", tcks, 46);

        // A zero-length request causes no TAP activity and responds on the next cycle.
        scan("len0", 1'b0, 7'd0, 64'hDEAD_BEEF_0000_FFFF, rsp, lat, tcks);
        check("len0.latency", lat, 0);
        check("len0.rsp", rsp, 64'h0);
        check("len0.tcks", tcks, 0);
        check("len0.tms", tms_o, 0);

        // A single-bit scan sets TMS=1 on its only shift bit.
        scan("len1", 1'b0, 7'd1, 64'h1, rsp, lat, tcks);
        check("len1.rsp", rsp, 64'h0);
        check("len1.tms_seq", tms_log & 64'h3F, 64'h26);
        check("len1.tcks", tcks, 6);

        // An oversize length is clamped to 64 shift bits.
        s0 = shdr_cnt;
        scan("len100", 1'b0, 7'd100, 64'hFFFF_FFFF_FFFF_FFFF, rsp, lat, tcks);
        check("len100.rsp", rsp, 64'hFFFF_FFFF_FFFF_FFFE);
        check("len100.tcks", tcks, 69);
        check("len100.shifts", shdr_cnt - s0, 64);

        // Reset arrives in the middle of a 32-bit DR scan.
        wait_ready("midrst");
        s0 = shdr_cnt;
        req_ir = 1'b0;
        req_len = 7'd32;
        req_data = 64'h0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        i = 0;
        while ((shdr_cnt - s0) < 10 && i < 2000) begin
            i++;
            @(negedge clk);
        end
        check("midrst.reached_bit10", shdr_cnt - s0, 10);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        nv = 0;
        for (int k = 0; k < 2000 && !req_ready_o; k++) begin
            if (rsp_valid_o) nv++;
            @(negedge clk);
        end
        check("midrst.no_rsp", nv, 0);
        check("midrst.ready", req_ready_o, 1);
        check("midrst.tap_rti", tap_st, RTI);
        check("midrst.tap_ir", tap_ir, 5'h01);
        scan("post_rst", 1'b0, 7'd32, 64'h0, rsp, lat, tcks);
        check("post_rst.rsp", rsp, 64'h0000_0000_2495_11C3);
        check("post_rst.tcks", tcks, 37);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jtag_tap_driver.md
Name: jtag_tap_driver

Overview:
- Synthesizable JTAG master: the host end of the JTAG link into the ariane debug TAP.
- Accepts IR or DR scan requests on a valid/ready port, generates TCK/TMS/TDI/TRSTn towards the DUT TAP, and returns captured TDO bits.
- Used in FPGA system testbenches, and in self-test wrappers, to drive debug-module accesses without an external probe.

Parameters:
MAX_LEN, 64, maximum scan length in bits; also the width of the request and response data.
CLK_DIV, 4, clk_i cycles per TCK half-period; must be ≥1.
LEN_W, $clog2(MAX_LEN)+1, width of the length field (derived; do not override).

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  1  scan request valid
req_ready_o  out  1  driver can accept a request
req_ir_i  in  1  1 = IR scan, 0 = DR scan
req_len_i  in  LEN_W  number of bits to shift
req_data_i  in  MAX_LEN  TDI bits, LSB shifted first
rsp_valid_o  out  1  one-cycle pulse: scan complete
rsp_data_o  out  MAX_LEN  captured TDO bits; bit i = i-th sampled bit
tck_o  out  1  JTAG TCK
tms_o  out  1  JTAG TMS
tdi_o  out  1  JTAG TDI
trst_no  out  1  JTAG TRSTn, active-low
tdo_i  in  1  JTAG TDO from DUT

Behaviour:
- Reset values (rst_i high): tck_o=0, tms_o=1, tdi_o=0, trst_no=0, req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, divider=0, FSM=TLR_SEQ.
- rst_i asserted mid-scan aborts the scan immediately. No rsp_valid_o is issued for the aborted scan.
- trst_no rises on the first clk_i cycle after rst_i deasserts.

TCK generation:
- Free-running. A divider counts 0..CLK_DIV-1; at terminal count tck_o toggles. Period = 2*CLK_DIV clk_i cycles.
- tms_o and tdi_o change only on the clk_i cycle where tck_o falls (1→0).
- tdo_i is sampled only on the clk_i cycle where tck_o rises (0→1).

FSM states:
- TLR_SEQ: drive TMS=1 for 5 TCK cycles, then TMS=0 for 1 cycle (TAP lands in Run-Test/Idle). Then go to IDLE.
- IDLE: tms_o=0, req_ready_o=1.
  - Handshake completes on req_valid_i & req_ready_o. Latch req_ir_i, req_len_i and req_data_i; clear rsp_data_o; drop req_ready_o next cycle.
  - req_len_i=0: no TAP activity; rsp_valid_o pulses on the next cycle with rsp_data_o=0; return to IDLE.
  - req_len_i>MAX_LEN: clamp to MAX_LEN.
- PRE: TMS sequence presented on successive falling edges.
  - DR scan: 1,0,0 (Select-DR, Capture-DR, Shift-DR).
  - IR scan: 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
- SHIFT: on the falling edge, tdi_o=data[k].
  - tms_o=0 for k<len-1; tms_o=1 for k=len-1 (Exit1).
  - On each rising edge in SHIFT, rsp_data_o[k]=tdo_i, then k++.
  - Bits ≥ len stay 0.
- POST: TMS 1 (Update), then 0 (Run-Test/Idle). After the rising edge that clocks the final TMS=0, go to DONE.
- DONE: rsp_valid_o=1 for exactly one clk_i cycle, then IDLE. req_ready_o is asserted in the cycle following DONE.

Timing and holds:
- Total TCK cycles per scan: DR = len+5, IR = len+6.
- rsp_data_o holds until the next accepted request.
- In IDLE, TMS stays 0 and tdi_o holds its last value; the TAP remains in Run-Test/Idle.
- req_valid_i asserted during a scan is ignored; there is no queueing.

Test Plan:
- Reset release, CLK_DIV=4: tck_o period 8 clk_i; observe 5×TMS=1 then TMS=0 -> TAP model in Run-Test/Idle; req_ready_o=1 after.
- IR scan, len=5, data=5'h11 (IDCODE... dtmcs 0x10 variant): TMS sequence 1,1,0,0,0,0,0,0,1,1,0 over 11 TCK -> TAP model IR=0x11; rsp_data_o = TAP IR capture 5'b00001; one rsp_valid_o pulse.
- DR scan, len=32, data=0, after IR=IDCODE -> rsp_data_o[31:0] = model IDCODE (e.g. 0x249511C3), bits 63:32 = 0; 37 TCK cycles.
- DR scan, len=41 (DMI), data=41'h1_2345_6789_A, against a loopback TDO=TDI-delayed-by-one model -> rsp_data_o equals the model-shifted pattern; len=1 case drives TMS=1 on the single shift bit.
- req_len_i=0 -> rsp_valid_o the next cycle, rsp_data_o=0, tck/tms quiet at TMS=0; req_len_i=100 -> 64 shift bits exactly.
- rst_i pulsed at shift bit 10 of a 32-bit DR scan -> outputs at reset values next cycle, no rsp_valid_o, TLR_SEQ replays, and a subsequent scan completes correctly.
